// File: rtl/sonar_pkg.sv
// ---------------------------------------------------------------------------
// sonar_pkg
// Shared definitions for the sonar ranging blocks and the downstream sonar
// logic unit: the ranging FSM state type, the published width format, and a
// saturating increment helper for the width counters.
// No ports (package).
// ---------------------------------------------------------------------------
package sonar_pkg;

   // Width of every published echo measurement word
   localparam int WIDTH_W = 16;

   // Saturation value; also the result code reported for a timeout
   localparam logic [WIDTH_W-1:0] WIDTH_SAT = 16'hFFFF;

   // Ranging cycle states
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      TRIG      = 3'd1,
      WAIT_RISE = 3'd2,
      MEASURE   = 3'd3,
      HOLDOFF   = 3'd4
   } sonar_state_t;

   // Increment that sticks at WIDTH_SAT instead of wrapping to zero
   function automatic logic [WIDTH_W-1:0] satInc(input logic [WIDTH_W-1:0] value);
      if (value == WIDTH_SAT) begin
         return value;
      end
      return value + {{(WIDTH_W-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/sync_edge.sv
// ---------------------------------------------------------------------------
// sync_edge
// Brings an asynchronous sensor input into the clk domain through a 2-FF
// synchroniser and produces single-cycle rise/fall pulses from the
// synchronised level.
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous active-high reset
//   i_async  in   raw input, asynchronous to clk
//   o_rise   out  1-cycle pulse on a 0->1 transition of the synchronised level
//   o_fall   out  1-cycle pulse on a 1->0 transition of the synchronised level
// ---------------------------------------------------------------------------
module sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic i_async,
   output logic o_rise,
   output logic o_fall
);

   logic r_meta;
   logic r_sync;
   logic r_prev;

   // Two flops resolve metastability; the third keeps the previous synchronised
   // level so edges can be detected without touching the metastable stage.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
         r_prev <= 1'b0;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign o_rise = r_sync & ~r_prev;
   assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/sonar_echo_timer.sv
// ---------------------------------------------------------------------------
// sonar_echo_timer
// Drives one ultrasonic ranger: issues a trigger pulse, then measures the
// echo high time in ticks of TICK_DIV clocks, publishing a 16-bit result with
// a one-cycle valid strobe. A missing echo is reported as a timeout.
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous active-high reset
//   enable       in   1 = range continuously; 0 = finish current cycle, then idle
//   echo         in   raw echo from the sensor (asynchronous)
//   trig         out  registered trigger to the sensor
//   echo_width   out  last measured width in ticks, held until the next result
//   width_valid  out  one-cycle strobe when echo_width/timeout update
//   timeout      out  last result was a timeout (echo_width = 16'hFFFF)
//   busy         out  state is not IDLE
// ---------------------------------------------------------------------------
module sonar_echo_timer
   import sonar_pkg::*;
#(
   parameter int TRIG_CYCLES   = 500,
   parameter int TICK_DIV      = 50,
   parameter int TIMEOUT_TICKS = 30000,
   parameter int PERIOD_CYCLES = 3_000_000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic               echo,
   output logic               trig,
   output logic [WIDTH_W-1:0] echo_width,
   output logic               width_valid,
   output logic               timeout,
   output logic               busy
);

   localparam int TRIG_W = $clog2(TRIG_CYCLES + 1);
   localparam int TICK_W = $clog2(TICK_DIV + 1);
   localparam int TMO_W  = $clog2(TIMEOUT_TICKS + 1);
   localparam int PER_W  = $clog2(PERIOD_CYCLES + 1);

   localparam logic [TRIG_W-1:0] TRIG_LAST = TRIG_W'(TRIG_CYCLES - 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
   localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_TICKS - 1);
   localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(PERIOD_CYCLES - 1);

   sonar_state_t        r_state;
   sonar_state_t        w_nextState;
   logic [TICK_W-1:0]   r_tickCnt;
   logic [TRIG_W-1:0]   r_trigCnt;
   logic [TMO_W-1:0]    r_tmoCnt;
   logic [PER_W-1:0]    r_perCnt;
   logic [WIDTH_W-1:0]  r_widthCnt;
   logic [WIDTH_W-1:0]  r_echoWidth;
   logic                r_trig;
   logic                r_valid;
   logic                r_timeout;

   logic                w_rise;
   logic                w_fall;
   logic                w_tick;
   logic                w_stateChange;
   logic                w_enterTrig;
   logic                w_periodDone;
   logic [WIDTH_W-1:0]  w_widthNext;

   sync_edge u_echoSync (
      .clk     (clk),
      .reset   (reset),
      .i_async (echo),
      .o_rise  (w_rise),
      .o_fall  (w_fall)
   );

   // Every state change restarts the tick divider, so the first tick after
   // entering a state is always a full TICK_DIV away. The period counter is
   // anchored to the clock edge that raises trig.
   assign w_tick        = (r_tickCnt == TICK_LAST);
   assign w_stateChange = (w_nextState != r_state);
   assign w_enterTrig   = (w_nextState == TRIG) && (r_state != TRIG);
   assign w_periodDone  = (r_perCnt >= PER_LAST);

   // A tick landing on the same edge as the falling echo still counts, so the
   // reported width is the echo time rounded down to whole ticks.
   assign w_widthNext = w_tick ? satInc(r_widthCnt) : r_widthCnt;

   // Next-state decode. A rising echo wins over a coincident timeout, and
   // MEASURE deliberately has no exit other than the falling echo.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (enable) begin
               w_nextState = TRIG;
            end
         end
         TRIG: begin
            if (r_trigCnt == TRIG_LAST) begin
               w_nextState = WAIT_RISE;
            end
         end
         WAIT_RISE: begin
            if (w_rise) begin
               w_nextState = MEASURE;
            end else if (w_tick && (r_tmoCnt == TMO_LAST)) begin
               w_nextState = HOLDOFF;
            end
         end
         MEASURE: begin
            if (w_fall) begin
               w_nextState = HOLDOFF;
            end
         end
         HOLDOFF: begin
            if (w_periodDone) begin
               w_nextState = enable ? TRIG : IDLE;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // State register plus trig; trig is high exactly while the FSM sits in TRIG,
   // and the async reset drops it immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_trig  <= 1'b0;
      end else begin
         r_state <= w_nextState;
         r_trig  <= (w_nextState == TRIG);
      end
   end

   // Tick divider: free-running modulo TICK_DIV, restarted on state entry.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_tickCnt <= '0;
      end else if (w_stateChange || w_tick) begin
         r_tickCnt <= '0;
      end else begin
         r_tickCnt <= r_tickCnt + TICK_W'(1);
      end
   end

   // Trigger length counter, counting clocks spent in TRIG.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_trigCnt <= '0;
      end else if (w_stateChange) begin
         r_trigCnt <= '0;
      end else if (r_state == TRIG) begin
         r_trigCnt <= r_trigCnt + TRIG_W'(1);
      end
   end

   // Echo wait counter, counting ticks spent in WAIT_RISE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_tmoCnt <= '0;
      end else if (w_stateChange) begin
         r_tmoCnt <= '0;
      end else if ((r_state == WAIT_RISE) && w_tick) begin
         r_tmoCnt <= r_tmoCnt + TMO_W'(1);
      end
   end

   // Period counter: restarts with each trig rise and stops once the minimum
   // period has elapsed, so a long cycle lets HOLDOFF exit on its first clock.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_perCnt <= '0;
      end else if (w_enterTrig) begin
         r_perCnt <= '0;
      end else if (!w_periodDone) begin
         r_perCnt <= r_perCnt + PER_W'(1);
      end
   end

   // Echo width counter, one count per tick in MEASURE, saturating.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_widthCnt <= '0;
      end else if (w_stateChange) begin
         r_widthCnt <= '0;
      end else if (r_state == MEASURE) begin
         r_widthCnt <= w_widthNext;
      end
   end

   // Result registers: width, timeout flag and the valid strobe all update on
   // the clock after the terminating edge or timeout, once per ranging cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_echoWidth <= '0;
         r_timeout   <= 1'b0;
         r_valid     <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if ((r_state == WAIT_RISE) && (w_nextState == HOLDOFF)) begin
            r_echoWidth <= WIDTH_SAT;
            r_timeout   <= 1'b1;
            r_valid     <= 1'b1;
         end else if ((r_state == MEASURE) && w_fall) begin
            r_echoWidth <= w_widthNext;
            r_timeout   <= 1'b0;
            r_valid     <= 1'b1;
         end
      end
   end

   assign trig        = r_trig;
   assign echo_width  = r_echoWidth;
   assign width_valid = r_valid;
   assign timeout     = r_timeout;
   assign busy        = (r_state != IDLE);

endmodule
